// File: rtl/bus_xfer_pkg.sv
// bus_xfer_pkg: shared state encoding and default width for the bus transfer sequencer.
package bus_xfer_pkg;
    localparam int DW_DEF = 8;
    typedef enum logic [2:0] {IDLE, READ, WRITE, INCR, DONE} state_t;
endpackage

// File: rtl/bus_src_mux.sv
// bus_src_mux: NREG:1 DW-bit source select; an index with no register behind it yields zero.
module bus_src_mux
    import bus_xfer_pkg::*;
#(
    parameter int NREG = 8,
    parameter int DW = DW_DEF,
    localparam int SELW = $clog2(NREG)
) (
    input  logic [SELW-1:0]    i_sel,
    input  logic [NREG*DW-1:0] i_data,
    output logic [DW-1:0]      o_data
);
    always_comb begin
        o_data = '0;
        for (int i = 0; i < NREG; i++)
            if (int'(i_sel) == i) o_data = i_data[i*DW +: DW];
    end
endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: reads one register onto BusOut, then pulses Wen (and optionally INC) into another.
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int NREG = 8,
    parameter int DW = DW_DEF,
    localparam int SELW = $clog2(NREG)
) (
    input  logic               Clk,
    input  logic               RST,
    input  logic               start,
    input  logic [SELW-1:0]    src_sel,
    input  logic [SELW-1:0]    dst_sel,
    input  logic               inc_dst,
    input  logic [NREG*DW-1:0] reg_dout,
    output logic [DW-1:0]      BusOut,
    output logic [NREG-1:0]    Wen,
    output logic [NREG-1:0]    INC,
    output logic               busy,
    output logic               done,
    output logic               err
);
    state_t            r_state, w_next;
    logic [SELW-1:0]   r_src, r_dst;
    logic              r_inc, r_oor;
    logic [DW-1:0]     r_bus, w_mux;
    logic [NREG-1:0]   w_hot;
    logic              w_oor;

    assign w_oor  = int'(src_sel) >= NREG || int'(dst_sel) >= NREG;
    assign w_hot  = r_oor ? '0 : {{(NREG-1){1'b0}}, 1'b1} << r_dst;
    assign BusOut = r_bus;

    bus_src_mux #(.NREG(NREG), .DW(DW)) u_mux (
        .i_sel  (r_src),
        .i_data (reg_dout),
        .o_data (w_mux)
    );

    always_ff @(posedge Clk or negedge RST)
        if (!RST) r_state <= IDLE;
        else r_state <= w_next;

    // Outputs decode only registered state so Wen/INC never glitch toward the register file.
    always_comb begin
        w_next = r_state;
        Wen = '0;
        INC = '0;
        busy = 1'b1;
        done = 1'b0;
        err = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                w_next = start ? READ : IDLE;
            end
            READ: w_next = WRITE;
            WRITE: begin
                Wen = w_hot;
                w_next = r_inc ? INCR : DONE;
            end
            INCR: begin
                INC = w_hot;
                w_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                err = r_oor;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RST)
        if (!RST) begin
            r_src <= '0;
            r_dst <= '0;
            r_inc <= 1'b0;
            r_oor <= 1'b0;
            r_bus <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_src <= src_sel;
                r_dst <= dst_sel;
                r_inc <= inc_dst;
                r_oor <= w_oor;
            end
            if (r_state == READ) r_bus <= r_oor ? '0 : w_mux;
        end
endmodule
